// File: rtl/n_bit_register_pkg.sv
// Shared defaults for the generic storage register.
// Kept separate so instantiating code can refer to the same widths.
package n_bit_register_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int MIN_WIDTH     = 1;

endpackage

// File: rtl/n_bit_register.sv
// Parameterised N-bit register with load enable and synchronous reset.
// Positional order out, in, en, clk, reset keeps legacy instances binding.
module n_bit_register
    import n_bit_register_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             clk,
    input  logic             reset
);

    generate
        if (WIDTH < MIN_WIDTH) begin : g_bad_width
            $error("n_bit_register: WIDTH must be at least 1");
        end
    endgenerate

    // Storage: reset has priority over load; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_VALUE;
        end else if (en) begin
            out <= in;
        end
    end

`ifndef SYNTHESIS
    logic seen_reset = 1'b0;

    // Remember that the register has been initialised at least once.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_reset <= 1'b1;
        end
    end

    a_no_x_after_reset : assert property (
        @(posedge clk) seen_reset |-> !$isunknown(out)
    ) else $error("n_bit_register: out is X after reset");

    a_hold_when_idle : assert property (
        @(posedge clk) (seen_reset && !en && !reset) |=> $stable(out)
    ) else $error("n_bit_register: out changed while idle");
`endif

endmodule

// File: tb/tb_n_bit_register.sv
// Scoreboard bench for n_bit_register.
// Three instances: default 16-bit, 1-bit and 32-bit with a custom reset.
module tb_n_bit_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] o16, i16;
    logic        e16, r16;
    logic [0:0]  o1, i1;
    logic        e1, r1;
    logic [31:0] o32, i32;
    logic        e32, r32;

    n_bit_register u16 (
        .out(o16), .in(i16), .en(e16), .clk(clk), .reset(r16)
    );

    n_bit_register #(.WIDTH(1)) u1 (
        .out(o1), .in(i1), .en(e1), .clk(clk), .reset(r1)
    );

    n_bit_register #(
        .WIDTH(32), .RESET_VALUE(32'hDEADBEEF)
    ) u32 (
        .out(o32), .in(i32), .en(e32), .clk(clk), .reset(r32)
    );

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Drive one DUT for the coming edge and queue its expected output.
    task automatic step(input int sel, input bit r, input bit e,
                        input logic [31:0] v, input logic [31:0] exp,
                        input string name);
        exp_t t;
        @(negedge clk);
        case (sel)
            16: begin r16 = r; e16 = e; i16 = v[15:0]; end
            1:  begin r1 = r; e1 = e; i1 = v[0:0]; end
            default: begin r32 = r; e32 = e; i32 = v; end
        endcase
        t.sel = sel;
        t.exp = exp;
        t.name = name;
        sb.push_back(t);
    endtask

    // Monitor: one queued expectation is checked after every edge.
    initial begin
        exp_t        t;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                t = sb.pop_front();
                case (t.sel)
                    16:      act = {16'h0, o16};
                    1:       act = {31'h0, o1};
                    default: act = o32;
                endcase
                compared++;
                if (act !== t.exp) begin
                    mismatched++;
                    $display("FAIL %s: got %h expected %h",
                             t.name, act, t.exp);
                end
            end
        end
    end

    initial begin
        int budget;
        r16 = 0; e16 = 0; i16 = '0;
        r1 = 0; e1 = 0; i1 = '0;
        r32 = 0; e32 = 0; i32 = '0;

        step(16, 1, 0, 0, 32'h0, "rst16");
        step(16, 0, 1, 36, 32'd36, "load36");
        step(16, 0, 0, 0, 32'd36, "in_chg_after");
        step(16, 0, 0, 26, 32'd36, "hold36");
        step(16, 0, 1, 9, 32'd9, "reload9");
        step(16, 0, 0, 0, 32'd9, "hold9a");
        step(16, 0, 0, 0, 32'd9, "hold9b");
        step(16, 1, 1, 32'hFFFF, 32'h0, "rst_beats_en");
        step(16, 0, 1, 32'hFFFF, 32'hFFFF, "load_ffff");
        step(16, 0, 1, 1, 32'd1, "b2b_1");
        step(16, 0, 1, 2, 32'd2, "b2b_2");
        step(16, 0, 1, 3, 32'd3, "b2b_3");
        step(16, 0, 1, 32'h8000, 32'h8000, "msb");
        step(16, 0, 1, 32'h0001, 32'h0001, "lsb");
        step(16, 1, 1, 32'hAAAA, 32'h0, "rst_held_1");
        step(16, 1, 1, 32'hAAAA, 32'h0, "rst_held_2");
        step(16, 0, 1, 32'h5555, 32'h5555, "load_after_rst");

        // Reset pulse between edges must be ignored.
        step(16, 0, 0, 0, 32'h5555, "rst_glitch");
        #1 r16 = 1;
        #1 r16 = 0;

        step(1, 1, 1, 1, 32'h0, "w1_rst");
        step(1, 0, 1, 1, 32'h1, "w1_load1");
        step(1, 0, 0, 0, 32'h1, "w1_hold");
        step(1, 0, 1, 0, 32'h0, "w1_load0");

        step(32, 1, 0, 0, 32'hDEADBEEF, "w32_rst");
        step(32, 0, 1, 32'h12345678, 32'h12345678, "w32_load");
        step(32, 0, 0, 32'hFFFFFFFF, 32'h12345678, "w32_hold");
        step(32, 1, 1, 32'h0, 32'hDEADBEEF, "w32_rst2");

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
